// File: rtl/fetch_stage_if.sv
// Instruction-memory channel between the fetch stage and instruction memory:
// a valid/ready request channel carrying the fetch address, and a valid-only
// response channel returning instructions in request order.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    // Fetch side: issues requests, consumes responses.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    // Memory side: accepts requests, produces responses.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register.
// Keeps at most one instruction-memory request in flight, absorbs decode
// stalls in a single-entry fetch buffer, and squashes wrong-path responses
// after a redirect from the decode-stage controller.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master imem,
    input  logic          PCsrc,
    input  logic [31:0]   br_target,
    input  logic          stall_D,
    input  logic          flush_D,
    output logic [31:0]   InstD,
    output logic [31:0]   PCD,
    output logic [31:0]   PCplus4D,
    output logic          validD
);

    // S_DRAIN doubles as the discard flag: the one outstanding response
    // belongs to a squashed path and is thrown away when it arrives.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] req_pc_q, req_pc_d;

    logic        fb_valid_q, fb_valid_d;
    logic [31:0] fb_inst_q, fb_inst_d;
    logic [31:0] fb_pc_q, fb_pc_d;

    logic [31:0] inst_q, inst_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        validd_q, validd_d;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        handshake;
    logic        b2b_ok;
    logic        resp_take;
    logic        resp_direct;
    logic        resp_to_fb;
    logic        fb_drain;

    // Fetch addresses are always word aligned, even for a misaligned target.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    assign req_addr = word_align(pcf_q);

    // A response consumed straight into IF/ID frees the single request slot
    // in the same cycle, so the next fetch can go out immediately. A flush
    // diverts that response into the buffer, so it also blocks the overlap
    // to keep the buffer from being targeted twice.
    assign b2b_ok = imem.imem_resp_valid && !stall_D && !flush_D
                    && !fb_valid_q && !PCsrc;

    // Fetch FSM: request generation and next-state selection.
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        resp_take = 1'b0;

        case (state_q)
            S_REQ: begin
                req_valid = !fb_valid_q;
            end
            S_WAIT: begin
                resp_take = imem.imem_resp_valid && !PCsrc;
                req_valid = b2b_ok;
            end
            default: begin
                req_valid = 1'b0;
            end
        endcase

        // No request may be presented while the stage is held in reset.
        req_valid = req_valid && rst_n;
        handshake = req_valid && imem.imem_req_ready;

        case (state_q)
            S_REQ: begin
                if (handshake) begin
                    state_d = PCsrc ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCsrc) begin
                    state_d = imem.imem_resp_valid ? S_REQ : S_DRAIN;
                end else if (imem.imem_resp_valid) begin
                    state_d = handshake ? S_WAIT : S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem.imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Response routing, fetch buffer, PC and IF/ID next values.
    always_comb begin
        resp_direct = resp_take && !stall_D && !flush_D && !fb_valid_q;
        resp_to_fb  = resp_take && !resp_direct;
        fb_drain    = fb_valid_q && !stall_D && !flush_D && !PCsrc;

        pcf_d = pcf_q;
        if (PCsrc) begin
            pcf_d = br_target;
        end else if (handshake) begin
            pcf_d = pcf_q + 32'd4;
        end

        req_pc_d = handshake ? req_addr : req_pc_q;

        fb_valid_d = fb_valid_q;
        fb_inst_d  = fb_inst_q;
        fb_pc_d    = fb_pc_q;
        if (PCsrc) begin
            fb_valid_d = 1'b0;
        end else begin
            if (fb_drain) begin
                fb_valid_d = 1'b0;
            end
            if (resp_to_fb) begin
                fb_valid_d = 1'b1;
                fb_inst_d  = imem.imem_resp_data;
                fb_pc_d    = req_pc_q;
            end
        end

        inst_d   = inst_q;
        pcd_d    = pcd_q;
        pcp4_d   = pcp4_q;
        validd_d = validd_q;
        if (flush_D || PCsrc) begin
            inst_d   = NOP_INSTR;
            validd_d = 1'b0;
        end else if (!stall_D) begin
            if (fb_valid_q) begin
                inst_d   = fb_inst_q;
                pcd_d    = fb_pc_q;
                pcp4_d   = fb_pc_q + 32'd4;
                validd_d = 1'b1;
            end else if (resp_direct) begin
                inst_d   = imem.imem_resp_data;
                pcd_d    = req_pc_q;
                pcp4_d   = req_pc_q + 32'd4;
                validd_d = 1'b1;
            end else begin
                inst_d   = NOP_INSTR;
                validd_d = 1'b0;
            end
        end
    end

    // Fetch control state: FSM, program counter, buffer occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pcf_q      <= RESET_PC;
            fb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            fb_valid_q <= fb_valid_d;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q   <= NOP_INSTR;
            pcd_q    <= 32'd0;
            pcp4_q   <= 32'd0;
            validd_q <= 1'b0;
        end else begin
            inst_q   <= inst_d;
            pcd_q    <= pcd_d;
            pcp4_q   <= pcp4_d;
            validd_q <= validd_d;
        end
    end

    // Payload registers; only ever read when qualified by control state.
    always_ff @(posedge clk) begin
        req_pc_q  <= req_pc_d;
        fb_inst_q <= fb_inst_d;
        fb_pc_q   <= fb_pc_d;
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = req_addr;

    assign InstD    = inst_q;
    assign PCD      = pcd_q;
    assign PCplus4D = pcp4_q;
    assign validD   = validd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected fetch
// addresses and IF/ID contents into queues; a monitor pops and compares
// whenever a request handshakes or decode consumes a valid IF/ID entry.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        PCsrc     = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        stall_D   = 1'b0;
    logic        flush_D   = 1'b0;
    logic [31:0] InstD;
    logic [31:0] PCD;
    logic [31:0] PCplus4D;
    logic        validD;

    fetch_stage_if imem ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .imem     (imem),
        .PCsrc    (PCsrc),
        .br_target(br_target),
        .stall_D  (stall_D),
        .flush_D  (flush_D),
        .InstD    (InstD),
        .PCD      (PCD),
        .PCplus4D (PCplus4D),
        .validD   (validD)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } id_t;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_req_q[$];
    id_t         exp_id_q[$];

    int          lat       = 1;
    bit          pend      = 1'b0;
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = 32'd0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'd0) ? 32'h0050_0093 : (32'hA000_0000 | a);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic push_id(input logic [31:0] pc);
        id_t e;
        e.inst = word(pc);
        e.pc   = pc;
        exp_id_q.push_back(e);
    endtask

    // One clock cycle: memory response, inputs, then record any handshake.
    task automatic cyc(input logic st, input logic pc, input logic [31:0] tgt,
                       input logic fl, input logic rdy);
        @(negedge clk);
        rst_n = 1'b1;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = 32'hDEAD_BEEF;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem.imem_resp_valid = 1'b1;
                imem.imem_resp_data  = word(pend_addr);
                pend = 1'b0;
            end
        end
        imem.imem_req_ready = rdy;
        stall_D   = st;
        PCsrc     = pc;
        br_target = tgt;
        flush_D   = fl;
        #1;
        if (imem.imem_req_valid && imem.imem_req_ready) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = imem.imem_req_addr;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check1 ({tag, "_req_valid"}, imem.imem_req_valid, 1'b0);
        check32({tag, "_InstD"},     InstD,    NOP);
        check32({tag, "_PCD"},       PCD,      32'd0);
        check32({tag, "_PCplus4D"},  PCplus4D, 32'd0);
        check1 ({tag, "_validD"},    validD,   1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pend  = 1'b0;
        lat   = 1;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = 32'd0;
        imem.imem_req_ready  = 1'b1;
        stall_D   = 1'b0;
        PCsrc     = 1'b0;
        flush_D   = 1'b0;
        br_target = 32'd0;
        exp_req_q.delete();
        exp_id_q.delete();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
    endtask

    task automatic end_scn(input string tag);
        #3;
        vectors++;
        if (exp_req_q.size() != 0 || exp_id_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_leftover: got %0d req / %0d id pending, expected 0 / 0",
                     tag, exp_req_q.size(), exp_id_q.size());
        end
    endtask

    // Monitor: compares every observed handshake and every consumed IF/ID entry.
    initial begin : monitor
        logic [31:0] ea;
        id_t         ei;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (imem.imem_req_valid && imem.imem_req_ready && exp_req_q.size() > 0) begin
                    ea = exp_req_q.pop_front();
                    check32("sb_req_addr", imem.imem_req_addr, ea);
                end
                if (validD && !stall_D && exp_id_q.size() > 0) begin
                    ei = exp_id_q.pop_front();
                    check32("sb_InstD",    InstD,    ei.inst);
                    check32("sb_PCD",      PCD,      ei.pc);
                    check32("sb_PCplus4D", PCplus4D, ei.pc + 32'd4);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        imem.imem_req_ready  = 1'b1;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = 32'd0;

        // Streaming from reset, then a 3-cycle decode stall.
        do_reset();
        for (int a = 0; a <= 16; a += 4) push_req(a);
        for (int a = 0; a <= 12; a += 4) push_id(a);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);                       // C1
        check1 ("A_c1_req_valid", imem.imem_req_valid, 1'b1);
        check32("A_c1_req_addr",  imem.imem_req_addr,  32'd0);
        run(2);                                                   // C2,C3
        check32("A_c3_InstD",    InstD,    32'h0050_0093);
        check32("A_c3_PCD",      PCD,      32'd0);
        check32("A_c3_PCplus4D", PCplus4D, 32'd4);
        check1 ("A_c3_validD",   validD,   1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);                       // C4
        for (int i = 0; i < 2; i++) begin                         // C5,C6
            cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
            check1 ("A_stall_req_valid", imem.imem_req_valid, 1'b0);
            check32("A_stall_PCD",       PCD,                 32'd4);
            check1 ("A_stall_validD",    validD,              1'b1);
        end
        run(3);                                                   // C7..C9
        check1("A_c9_validD", validD, 1'b0);
        run(2);
        end_scn("A");

        // Redirect while the request for 0x20 is still outstanding.
        do_reset();
        for (int a = 0; a <= 32; a += 4) push_req(a);
        push_req(32'h100);
        for (int a = 0; a <= 28; a += 4) push_id(a);
        push_id(32'h100);
        run(8);                                                   // C1..C8
        lat = 3;
        run(1);                                                   // C9
        cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);                     // C10
        lat = 1;
        for (int i = 0; i < 2; i++) begin                         // C11,C12
            run(1);
            check1("C_drain_validD",    validD,              1'b0);
            check1("C_drain_req_valid", imem.imem_req_valid, 1'b0);
        end
        run(1);                                                   // C13
        check1 ("C_c13_validD",    validD,              1'b0);
        check1 ("C_c13_req_valid", imem.imem_req_valid, 1'b1);
        check32("C_c13_req_addr",  imem.imem_req_addr,  32'h100);
        run(1);                                                   // C14
        check1("C_c14_validD", validD, 1'b0);
        run(2);
        end_scn("C");

        // Redirect coinciding with a response, misaligned target.
        do_reset();
        push_req(32'h0);
        push_req(32'h200);
        push_req(32'h204);
        push_id(32'h200);
        run(1);                                                   // C1
        cyc(1'b0, 1'b1, 32'h202, 1'b0, 1'b1);                     // C2
        check1("D_c2_req_valid", imem.imem_req_valid, 1'b0);
        run(1);                                                   // C3
        check1 ("D_c3_validD",    validD,              1'b0);
        check1 ("D_c3_req_valid", imem.imem_req_valid, 1'b1);
        check32("D_c3_req_addr",  imem.imem_req_addr,  32'h200);
        run(3);
        end_scn("D");

        // Memory not ready: request held stable, PC advances only on handshake.
        do_reset();
        push_req(32'h0);
        push_req(32'h4);
        push_req(32'h8);
        push_id(32'h0);
        push_id(32'h4);
        for (int i = 0; i < 4; i++) begin                         // C1..C4
            cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            check1 ("E_hold_req_valid", imem.imem_req_valid, 1'b1);
            check32("E_hold_req_addr",  imem.imem_req_addr,  32'h0);
        end
        run(1);                                                   // C5
        for (int i = 0; i < 2; i++) begin                         // C6,C7
            cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            check1 ("E_b2b_req_valid", imem.imem_req_valid, 1'b1);
            check32("E_b2b_req_addr",  imem.imem_req_addr,  32'h4);
        end
        run(4);
        end_scn("E");

        // Asynchronous reset while a request is outstanding.
        do_reset();
        push_req(32'h0);
        push_req(32'h4);
        push_req(32'h8);
        push_id(32'h0);
        push_id(32'h4);
        run(2);
        lat = 5;
        run(2);                                                   // C3,C4
        end_scn("F1");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");

        // Clean restart, then flush with stall held: flush wins.
        do_reset();
        push_req(32'h0);
        push_req(32'h4);
        push_req(32'h8);
        push_id(32'h0);
        push_id(32'h8);
        run(2);
        lat = 3;
        run(1);                                                   // C3
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);                       // C4
        run(1);                                                   // C5
        check1 ("F_flush_validD",    validD,              1'b0);
        check32("F_flush_InstD",     InstD,               NOP);
        check1 ("F_flush_req_valid", imem.imem_req_valid, 1'b0);
        run(3);
        end_scn("F2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
